// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter and sequencer for the shared 32-bit ALU.
// Two requesters are served one at a time. The accepted op drives the ALU from registers for
// one cycle, and the result comes back on a tagged response channel that can be back-pressured.
// The architectural status-flag register is owned here.
module alu_share_arb #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    // requester 0
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [2:0]  r0_gin,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic        r0_stswrite,
    // requester 1
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [2:0]  r1_gin,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic        r1_stswrite,
    // shared ALU
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_gin,
    output logic        alu_stswrite,
    input  logic [31:0] alu_sum,
    input  logic [2:0]  alu_status,
    // response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_sum,
    output logic [2:0]  rsp_status,
    output logic        rsp_err
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant;
    logic        accept;

    // latched request
    logic [2:0]  gin_q;
    logic [31:0] a_q, b_q;
    logic        sw_q;
    logic        id_q;
    logic        illegal_q;

    // response and flag registers
    logic [31:0] rsp_sum_q;
    logic        rsp_id_q;
    logic        rsp_err_q;
    logic [2:0]  flags_q;

    logic [2:0]  sel_gin;
    logic [31:0] sel_a, sel_b;
    logic        sel_sw;
    logic        sel_illegal;

    // Pick the winner: the lone valid requester, or the one not served last on contention.
    always_comb begin
        grant = 1'b0;
        if (r0_valid && r1_valid) begin
            grant = ~last_grant_q;
        end else if (r1_valid) begin
            grant = 1'b1;
        end
    end

    assign r0_ready = (state_q == StIdle) && r0_valid && !grant;
    assign r1_ready = (state_q == StIdle) && r1_valid && grant;
    assign accept   = r0_ready || r1_ready;

    assign sel_gin     = grant ? r1_gin      : r0_gin;
    assign sel_a       = grant ? r1_a        : r0_a;
    assign sel_b       = grant ? r1_b        : r0_b;
    assign sel_sw      = grant ? r1_stswrite : r0_stswrite;
    assign sel_illegal = (sel_gin == 3'b011) || (sel_gin == 3'b100);

    // Next state and round-robin pointer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d      = StExec;
                    last_grant_d = grant;
                end
            end
            StExec:  state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and last-grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= ~PRIO_INIT;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Latch the granted request on handshake; these registers drive the ALU directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gin_q     <= 3'b000;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            sw_q      <= 1'b0;
            id_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            gin_q     <= sel_gin;
            a_q       <= sel_a;
            b_q       <= sel_b;
            // an illegal op never asks the ALU to update status
            sw_q      <= sel_sw && !sel_illegal;
            id_q      <= grant;
            illegal_q <= sel_illegal;
        end
    end

    // Capture the ALU result and update flags at the end of the EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_sum_q <= 32'd0;
            rsp_id_q  <= 1'b0;
            rsp_err_q <= 1'b0;
            flags_q   <= 3'b000;
        end else if (state_q == StExec) begin
            rsp_sum_q <= illegal_q ? 32'd0 : alu_sum;
            rsp_id_q  <= id_q;
            rsp_err_q <= illegal_q;
            if (sw_q) begin
                flags_q <= alu_status;
            end
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_gin      = gin_q;
    assign alu_stswrite = sw_q;

    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = rsp_id_q;
    assign rsp_sum    = rsp_sum_q;
    assign rsp_status = flags_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: behavioural ALU on the ALU port, plus a transaction-level
// reference model predicting grant order, results and flag register.
module tb_alu_share_arb;

    typedef struct packed {
        logic [2:0]  gin;
        logic [31:0] a;
        logic [31:0] b;
        logic        sw;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic        r0_ready, r1_ready;
    logic [2:0]  r0_gin = '0, r1_gin = '0;
    logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic        r0_stswrite = 1'b0, r1_stswrite = 1'b0;
    logic [31:0] alu_a, alu_b, alu_sum;
    logic [2:0]  alu_gin, alu_status;
    logic        alu_stswrite;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err;
    logic [31:0] rsp_sum;
    logic [2:0]  rsp_status;

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    bit       model_last = 1'b1;  // ~PRIO_INIT with PRIO_INIT = 0
    bit [2:0] model_flags = 3'b000;

    always #5 clk = ~clk;

    alu_share_arb #(.PRIO_INIT(1'b0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r0_valid     (r0_valid),
        .r0_ready     (r0_ready),
        .r0_gin       (r0_gin),
        .r0_a         (r0_a),
        .r0_b         (r0_b),
        .r0_stswrite  (r0_stswrite),
        .r1_valid     (r1_valid),
        .r1_ready     (r1_ready),
        .r1_gin       (r1_gin),
        .r1_a         (r1_a),
        .r1_b         (r1_b),
        .r1_stswrite  (r1_stswrite),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_gin      (alu_gin),
        .alu_stswrite (alu_stswrite),
        .alu_sum      (alu_sum),
        .alu_status   (alu_status),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_status   (rsp_status),
        .rsp_err      (rsp_err)
    );

    // Behavioural ALU: returns {zero, negative, overflow, sum}; illegal codes give junk.
    function automatic logic [34:0] ref_alu(input logic [2:0] g, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, full;
        logic [31:0] s;
        bit ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = 1'b0;
        s   = '0;
        case (g)
            3'b010: begin
                full = sa + sb;
                s    = a + b;
                ovf  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            3'b110: begin
                full = sa - sb;
                s    = a - b;
                ovf  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            3'b111: s = (sa < sb) ? 32'd1 : 32'd0;
            3'b000: s = a & b;
            3'b001: s = a | b;
            3'b101: s = a << b[4:0];
            default: return {3'b111, 32'hdead_beef};
        endcase
        return {(s == 32'd0), s[31], ovf, s};
    endfunction

    always_comb {alu_status, alu_sum} = ref_alu(alu_gin, alu_a, alu_b);

    function automatic op_t mk(input logic [2:0] g, input logic [31:0] a, input logic [31:0] b,
                               input logic sw);
        op_t o;
        o.gin = g;
        o.a   = a;
        o.b   = b;
        o.sw  = sw;
        return o;
    endfunction

    function automatic op_t rnd_op();
        return mk(3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    endfunction

    // One complete transaction starting in IDLE (called just after a rising edge).
    task automatic do_op(input bit v0, input bit v1, input op_t o0, input op_t o1, input int bp,
                         input string tag);
        bit          w, eerr, esw;
        op_t         o;
        logic [34:0] r;
        logic [31:0] esum;
        if (v0 && !v1) w = 1'b0;
        else if (v1 && !v0) w = 1'b1;
        else w = ~model_last;
        model_last = w;
        o    = w ? o1 : o0;
        eerr = (o.gin == 3'b011) || (o.gin == 3'b100);
        r    = ref_alu(o.gin, o.a, o.b);
        esum = eerr ? 32'd0 : r[31:0];
        esw  = o.sw && !eerr;
        if (esw) model_flags = r[34:32];

        r0_valid = v0; r0_gin = o0.gin; r0_a = o0.a; r0_b = o0.b; r0_stswrite = o0.sw;
        r1_valid = v1; r1_gin = o1.gin; r1_a = o1.a; r1_b = o1.b; r1_stswrite = o1.sw;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if ({r0_ready, r1_ready} !== {~w, w})
            $display("FAIL %s grant: ready0/1 got %b%b want %b%b", tag, r0_ready, r1_ready,
                     ~w, w);
        else n_pass++;

        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({rsp_valid, alu_gin, alu_a, alu_b, alu_stswrite} !== {1'b0, o.gin, o.a, o.b, esw})
            $display("FAIL %s exec: vld/gin/a/b/sw got %b %b %h %h %b want 0 %b %h %h %b", tag,
                     rsp_valid, alu_gin, alu_a, alu_b, alu_stswrite, o.gin, o.a, o.b, esw);
        else n_pass++;

        @(posedge clk); #1;
        // requesters keep pressing during RESP; nothing may be accepted
        r0_valid = v0;
        r1_valid = v1;
        for (int i = 0; i <= bp; i++) begin
            if (i == bp) rsp_ready = 1'b1;
            @(negedge clk);
            n_total++;
            if ({rsp_valid, rsp_id, rsp_sum, rsp_status, rsp_err, r0_ready, r1_ready} !==
                {1'b1, w, esum, model_flags, eerr, 2'b00})
                $display("FAIL %s resp[%0d]: v/id/sum/st/err/rdy got %b %b %h %b %b %b%b want 1 %b %h %b %b 00",
                         tag, i, rsp_valid, rsp_id, rsp_sum, rsp_status, rsp_err, r0_ready,
                         r1_ready, w, esum, model_flags, eerr);
            else n_pass++;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        r0_valid  = 1'b0;
        r1_valid  = 1'b0;
    endtask

    task automatic check_all_reset(input string tag);
        n_total++;
        if ({r0_ready, r1_ready, rsp_valid, rsp_id, rsp_sum, rsp_status, rsp_err, alu_a, alu_b,
             alu_gin, alu_stswrite} !== '0)
            $display("FAIL %s: rdy %b%b vld %b id %b sum %h st %b err %b a %h b %h gin %b sw %b want all 0",
                     tag, r0_ready, r1_ready, rsp_valid, rsp_id, rsp_sum, rsp_status, rsp_err,
                     alu_a, alu_b, alu_gin, alu_stswrite);
        else n_pass++;
    endtask

    task automatic test_reset();
        #3;
        check_all_reset("reset_values");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        // idle with no requests: nothing happens
        @(negedge clk);
        n_total++;
        if ({r0_ready, r1_ready, rsp_valid} !== 3'b000)
            $display("FAIL idle_quiet: rdy/vld got %b%b%b want 000", r0_ready, r1_ready,
                     rsp_valid);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++)
            do_op(1'b1, 1'b1, mk(3'b010, 32'(i), 32'd100, 1'b0),
                  mk(3'b001, 32'(i), 32'h10, 1'b0), 0, "contention");
    endtask

    task automatic test_single();
        do_op(1'b1, 1'b0, mk(3'b010, 32'd5, 32'd7, 1'b1), mk(3'b000, '0, '0, 1'b0), 0,
              "single_add");
        // same lone requester again: served without waiting
        do_op(1'b1, 1'b0, mk(3'b111, 32'hffff_fff0, 32'd3, 1'b0), mk(3'b000, '0, '0, 1'b0), 0,
              "single_again");
    endtask

    task automatic test_flag_hold();
        do_op(1'b0, 1'b1, mk(3'b000, '0, '0, 1'b0), mk(3'b110, 32'd3, 32'd3, 1'b1), 0,
              "flag_sub");
        do_op(1'b0, 1'b1, mk(3'b000, '0, '0, 1'b0), mk(3'b001, 32'd1, 32'd2, 1'b0), 0,
              "flag_hold_or");
        n_total++;
        if (rsp_status !== 3'b100)
            $display("FAIL flag_hold_value: status got %b want 100", rsp_status);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_op(1'b1, 1'b0, mk(3'b010, 32'h7fff_ffff, 32'd1, 1'b1), mk(3'b000, '0, '0, 1'b0), 0,
              "overflow");
        n_total++;
        if ({rsp_sum, rsp_status} !== {32'h8000_0000, 3'b011})
            $display("FAIL overflow_value: sum/status got %h %b want 80000000 011", rsp_sum,
                     rsp_status);
        else n_pass++;
    endtask

    task automatic test_illegal_backpressure();
        do_op(1'b1, 1'b1, mk(3'b011, 32'd9, 32'd9, 1'b1), mk(3'b100, 32'd1, 32'd1, 1'b1), 4,
              "illegal_bp");
        do_op(1'b0, 1'b1, mk(3'b000, '0, '0, 1'b0), mk(3'b010, 32'd1, 32'd2, 1'b0), 2,
              "bp_legal");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            do_op(sel[0], sel[1], rnd_op(), rnd_op(), int'($urandom_range(0, 2)), "random");
        end
    endtask

    task automatic test_reset_mid_exec();
        // leave nonzero flags behind so the clear is visible
        do_op(1'b1, 1'b0, mk(3'b110, 32'd4, 32'd4, 1'b1), mk(3'b000, '0, '0, 1'b0), 0,
              "pre_reset");
        r0_valid = 1'b1; r0_gin = 3'b010; r0_a = 32'd11; r0_b = 32'd22; r0_stswrite = 1'b1;
        @(posedge clk); #1;
        r0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_reset("reset_mid_exec");
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({rsp_valid, rsp_status} !== 4'b0000)
            $display("FAIL reset_no_resp: vld/status got %b %b want 0 000", rsp_valid,
                     rsp_status);
        else n_pass++;
        rst_n = 1'b1;
        model_last  = 1'b1;
        model_flags = 3'b000;
        @(posedge clk); #1;
        do_op(1'b1, 1'b1, mk(3'b001, 32'd1, 32'd4, 1'b0), mk(3'b010, 32'd1, 32'd1, 1'b0), 0,
              "after_reset_prio");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_flag_hold();
        test_overflow();
        test_illegal_backpressure();
        test_random();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
